// File: rtl/memory_access_pkg.sv
// Shared pipeline definitions used by the memory-access stage.
package memory_access_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   localparam int MEM_READ  = 1;
   localparam int MEM_WRITE = 0;

endpackage

// File: rtl/memory_access.sv
// Pipeline memory-access stage: drives the data cache, freezes the pipeline on a
// cache stall and holds the MEM/WB register until the access completes.
module memory_access
   import memory_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        WriteBack_3,
   input  logic [1:0]  Mem_3,
   input  logic [31:0] ALU_result_3,
   input  logic [31:0] writedata_3,
   input  logic [4:0]  Rd_3,
   output logic        DCACHE_ren,
   output logic        DCACHE_wen,
   output logic [29:0] DCACHE_addr,
   output logic [31:0] DCACHE_wdata,
   input  logic [31:0] DCACHE_rdata,
   input  logic        DCACHE_stall,
   output logic        memory_stall,
   output logic        WriteBack_5,
   output logic [4:0]  Rd_5,
   output logic [31:0] writeback_data_5,
   output logic        misaligned,
   output logic [31:0] stall_count
);

   mem_state_t  state_q, state_d;
   logic        req;
   logic        wb_q, wb_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] data_q, data_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] stall_count_q, stall_count_d;

   // A 2'b11 encoding is treated as a plain read.
   assign req = Mem_3[MEM_READ] | Mem_3[MEM_WRITE];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req && DCACHE_stall) state_d = WAIT;
         WAIT:    if (!DCACHE_stall)       state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      DCACHE_ren   = Mem_3[MEM_READ];
      DCACHE_wen   = Mem_3[MEM_WRITE] & ~Mem_3[MEM_READ];
      DCACHE_addr  = ALU_result_3[31:2];
      DCACHE_wdata = writedata_3;
      memory_stall = req & DCACHE_stall;
   end

   always_comb begin
      wb_d          = wb_q;
      rd_d          = rd_q;
      data_d        = data_q;
      misaligned_d  = misaligned_q | (req & (ALU_result_3[1:0] != 2'b00));
      stall_count_d = stall_count_q + {31'd0, memory_stall};
      if (!memory_stall) begin
         wb_d   = WriteBack_3 & (Rd_3 != 5'd0);
         rd_d   = Rd_3;
         data_d = Mem_3[MEM_READ] ? DCACHE_rdata : ALU_result_3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q          <= 1'b0;
         rd_q          <= 5'd0;
         data_q        <= 32'd0;
         misaligned_q  <= 1'b0;
         stall_count_q <= 32'd0;
      end else begin
         wb_q          <= wb_d;
         rd_q          <= rd_d;
         data_q        <= data_d;
         misaligned_q  <= misaligned_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign WriteBack_5      = wb_q;
   assign Rd_5             = rd_q;
   assign writeback_data_5 = data_q;
   assign misaligned       = misaligned_q;
   assign stall_count      = stall_count_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: single-cycle vector table plus hand-written
// miss, reset-in-wait and misaligned/x0 sequences.
module tb_memory_access;
   import memory_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        WriteBack_3;
   logic [1:0]  Mem_3;
   logic [31:0] ALU_result_3;
   logic [31:0] writedata_3;
   logic [4:0]  Rd_3;
   logic        DCACHE_ren;
   logic        DCACHE_wen;
   logic [29:0] DCACHE_addr;
   logic [31:0] DCACHE_wdata;
   logic [31:0] DCACHE_rdata;
   logic        DCACHE_stall;
   logic        memory_stall;
   logic        WriteBack_5;
   logic [4:0]  Rd_5;
   logic [31:0] writeback_data_5;
   logic        misaligned;
   logic [31:0] stall_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_access dut (
      .clk              (clk),
      .rst              (rst),
      .WriteBack_3      (WriteBack_3),
      .Mem_3            (Mem_3),
      .ALU_result_3     (ALU_result_3),
      .writedata_3      (writedata_3),
      .Rd_3             (Rd_3),
      .DCACHE_ren       (DCACHE_ren),
      .DCACHE_wen       (DCACHE_wen),
      .DCACHE_addr      (DCACHE_addr),
      .DCACHE_wdata     (DCACHE_wdata),
      .DCACHE_rdata     (DCACHE_rdata),
      .DCACHE_stall     (DCACHE_stall),
      .memory_stall     (memory_stall),
      .WriteBack_5      (WriteBack_5),
      .Rd_5             (Rd_5),
      .writeback_data_5 (writeback_data_5),
      .misaligned       (misaligned),
      .stall_count      (stall_count)
   );

   typedef struct {
      logic        wb;
      logic [1:0]  mem;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        dst;
      logic        e_ren;
      logic        e_wen;
      logic        e_ms;
      logic [29:0] e_addr;
      logic        e_wb5;
      logic [4:0]  e_rd5;
      logic [31:0] e_d5;
      logic        e_mis;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic wb, input logic [1:0] mem, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic dst);
      WriteBack_3  = wb;
      Mem_3        = mem;
      ALU_result_3 = alu;
      writedata_3  = wd;
      Rd_3         = rd;
      DCACHE_rdata = rdata;
      DCACHE_stall = dst;
   endtask

   task automatic chk_s5(input string tag, input logic wb, input logic [4:0] rd, input logic [31:0] d);
      chk({tag, ".wb5"}, {31'd0, WriteBack_5}, {31'd0, wb});
      chk({tag, ".rd5"}, {27'd0, Rd_5}, {27'd0, rd});
      chk({tag, ".d5"},  writeback_data_5, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          wb  mem    alu           rd    rdata         dst  ren  wen  ms   addr          wb5  rd5   d5            mis  cnt
      vecs[0] = '{1'b1, 2'b00, 32'h00001234, 5'd5, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 30'h48D, 1'b1, 5'd5, 32'h00001234, 1'b0, 32'd0};
      vecs[1] = '{1'b1, 2'b10, 32'h00000040, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 30'h10,  1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'd0};
      vecs[2] = '{1'b0, 2'b01, 32'h00000080, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 30'h20,  1'b0, 5'd0, 32'h00000080, 1'b0, 32'd0};
      vecs[3] = '{1'b1, 2'b11, 32'h00000100, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 30'h40,  1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 32'd0};
      vecs[4] = '{1'b1, 2'b00, 32'h00000055, 5'd9, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 30'h15,  1'b1, 5'd9, 32'h00000055, 1'b0, 32'd0};
      vecs[5] = '{1'b1, 2'b00, 32'h00000077, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 30'h1D,  1'b0, 5'd0, 32'h00000077, 1'b0, 32'd0};
      vecs[6] = '{1'b1, 2'b10, 32'h00000200, 5'd4, 32'h00000099, 1'b1, 1'b1, 1'b0, 1'b1, 30'h80,  1'b0, 5'd0, 32'h00000077, 1'b0, 32'd1};
      vecs[7] = '{1'b1, 2'b10, 32'h00000200, 5'd4, 32'h00000099, 1'b0, 1'b1, 1'b0, 1'b0, 30'h80,  1'b1, 5'd4, 32'h00000099, 1'b0, 32'd1};

      rst = 1'b1;
      set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
      tick();
      tick();
      chk_s5("reset", 1'b0, 5'd0, 32'd0);
      chk("reset.mis", {31'd0, misaligned}, 32'd0);
      chk("reset.cnt", stall_count, 32'd0);
      $display("txn reset: wb5=%0b rd5=%0d d5=%h cnt=%0d", WriteBack_5, Rd_5, writeback_data_5, stall_count);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i].wb, vecs[i].mem, vecs[i].alu, 32'h11112222, vecs[i].rd, vecs[i].rdata, vecs[i].dst);
         #1;
         chk($sformatf("vec%0d.ren", i),  {31'd0, DCACHE_ren},   {31'd0, vecs[i].e_ren});
         chk($sformatf("vec%0d.wen", i),  {31'd0, DCACHE_wen},   {31'd0, vecs[i].e_wen});
         chk($sformatf("vec%0d.ms", i),   {31'd0, memory_stall}, {31'd0, vecs[i].e_ms});
         chk($sformatf("vec%0d.addr", i), {2'd0, DCACHE_addr},   {2'd0, vecs[i].e_addr});
         tick();
         chk_s5($sformatf("vec%0d", i), vecs[i].e_wb5, vecs[i].e_rd5, vecs[i].e_d5);
         chk($sformatf("vec%0d.mis", i), {31'd0, misaligned}, {31'd0, vecs[i].e_mis});
         chk($sformatf("vec%0d.cnt", i), stall_count, vecs[i].e_cnt);
         $display("txn vec%0d: mem=%b alu=%h wb5=%0b rd5=%0d d5=%h cnt=%0d",
                  i, vecs[i].mem, vecs[i].alu, WriteBack_5, Rd_5, writeback_data_5, stall_count);
      end

      // Load miss: three stall cycles, garbage on rdata until the cache releases.
      for (int c = 0; c < 3; c++) begin
         set_in(1'b1, 2'b10, 32'h00000300, 32'h0, 5'd6, 32'hBAD0BAD0, 1'b1);
         #1;
         chk($sformatf("ldmiss%0d.ms", c), {31'd0, memory_stall}, 32'd1);
         tick();
         chk_s5($sformatf("ldmiss%0d", c), 1'b1, 5'd4, 32'h00000099);
      end
      chk("ldmiss.cnt", stall_count, 32'd4);
      set_in(1'b1, 2'b10, 32'h00000300, 32'h0, 5'd6, 32'h12345678, 1'b0);
      #1;
      chk("ldmiss.done.ms", {31'd0, memory_stall}, 32'd0);
      tick();
      chk_s5("ldmiss.done", 1'b1, 5'd6, 32'h12345678);
      chk("ldmiss.done.cnt", stall_count, 32'd4);
      $display("txn load-miss: d5=%h cnt=%0d", writeback_data_5, stall_count);

      // Store miss: two stall cycles, request must stay stable.
      for (int c = 0; c < 2; c++) begin
         set_in(1'b0, 2'b01, 32'h00000400, 32'hA5A5A5A5, 5'd0, 32'hFFFFFFFF, 1'b1);
         #1;
         chk($sformatf("stmiss%0d.wen", c), {31'd0, DCACHE_wen}, 32'd1);
         chk($sformatf("stmiss%0d.wdata", c), DCACHE_wdata, 32'hA5A5A5A5);
         chk($sformatf("stmiss%0d.ms", c), {31'd0, memory_stall}, 32'd1);
         tick();
         chk_s5($sformatf("stmiss%0d", c), 1'b1, 5'd6, 32'h12345678);
      end
      set_in(1'b0, 2'b01, 32'h00000400, 32'hA5A5A5A5, 5'd0, 32'hFFFFFFFF, 1'b0);
      tick();
      chk_s5("stmiss.done", 1'b0, 5'd0, 32'h00000400);
      chk("stmiss.done.cnt", stall_count, 32'd6);
      $display("txn store-miss: d5=%h cnt=%0d", writeback_data_5, stall_count);

      // Reset asserted during the second stall cycle of a load miss.
      set_in(1'b1, 2'b10, 32'h00000500, 32'h0, 5'd8, 32'h0, 1'b1);
      tick();
      chk("rstwait.cnt1", stall_count, 32'd7);
      chk("rstwait.state1", {31'd0, dut.state_q}, {31'd0, WAIT});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstwait.state", {31'd0, dut.state_q}, {31'd0, IDLE});
      chk_s5("rstwait", 1'b0, 5'd0, 32'd0);
      chk("rstwait.cnt", stall_count, 32'd0);
      chk("rstwait.mis", {31'd0, misaligned}, 32'd0);
      set_in(1'b1, 2'b00, 32'h00000009, 32'h0, 5'd2, 32'h0, 1'b0);
      #1;
      chk("rstwait.next.ms", {31'd0, memory_stall}, 32'd0);
      tick();
      chk_s5("rstwait.next", 1'b1, 5'd2, 32'h00000009);
      $display("txn reset-in-wait: state=%0d cnt=%0d", dut.state_q, stall_count);

      // Misaligned load to x0, then an aligned op: flag stays set.
      set_in(1'b1, 2'b10, 32'h00000043, 32'h0, 5'd0, 32'h00005555, 1'b0);
      #1;
      chk("mis.addr", {2'd0, DCACHE_addr}, 32'h10);
      tick();
      chk_s5("mis", 1'b0, 5'd0, 32'h00005555);
      chk("mis.flag", {31'd0, misaligned}, 32'd1);
      set_in(1'b1, 2'b00, 32'h00000010, 32'h0, 5'd1, 32'h0, 1'b0);
      tick();
      chk("mis.sticky", {31'd0, misaligned}, 32'd1);
      chk_s5("mis.after", 1'b1, 5'd1, 32'h00000010);
      $display("txn misaligned-x0: mis=%0b wb5=%0b", misaligned, WriteBack_5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
